// File: rtl/digit_feature_extractor_pkg.sv
// -----------------------------------------------------------------------------
// digit_feature_extractor_pkg
//
// Shared constants for the digit feature extractor and the perceptron
// classifier that consumes its output:
//   - feature widths and saturation limits (edges, curves)
//   - FSM state encodings for the extractor
//   - default frame geometry
//   - width helpers for the per-row segment and popcount values
// -----------------------------------------------------------------------------
package digit_feature_extractor_pkg;

   // Classifier feature widths and saturation ceilings.
   localparam int EDGE_W  = 3;
   localparam int CURVE_W = 4;
   localparam logic [EDGE_W-1:0]  EDGE_MAX  = 3'd7;
   localparam logic [CURVE_W-1:0] CURVE_MAX = 4'd15;

   // Default frame geometry.
   localparam int DEF_ROWS       = 8;
   localparam int DEF_WIDTH      = 8;
   localparam int DEF_MIN_STROKE = 4;

   // Extractor FSM states, kept as plain constants for compatibility with
   // existing code that compares against raw encodings.
   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t ACCUM = 2'd1;
   localparam state_t DONE  = 2'd2;

   // Bits needed for the segment count of a row (0 .. ceil(width/2)).
   function automatic int seg_width(input int width);
      return $clog2((width + 1) / 2 + 1);
   endfunction

   // Bits needed for the popcount of a row (0 .. width).
   function automatic int pop_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/digit_feature_extractor_row_analyzer.sv
// -----------------------------------------------------------------------------
// digit_feature_extractor_row_analyzer
//
// Purely combinational analysis of one bitmap row.
//
// Ports:
//   row_data  in   WIDTH  pixel row, bit i = column i, 1 = ink
//   seg       out  SEG_W  number of ink runs (0->1 starts scanning from bit 0,
//                         a set bit 0 counts as a start)
//   pop       out  POP_W  number of ink pixels
//   stroke    out  1      single run with at least MIN_STROKE pixels
// -----------------------------------------------------------------------------
module digit_feature_extractor_row_analyzer
   import digit_feature_extractor_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int MIN_STROKE = DEF_MIN_STROKE,
   localparam int SEG_W     = seg_width(WIDTH),
   localparam int POP_W     = pop_width(WIDTH)
) (
   input  logic [WIDTH-1:0] row_data,
   output logic [SEG_W-1:0] seg,
   output logic [POP_W-1:0] pop,
   output logic             stroke
);

   localparam logic [POP_W-1:0] MIN_POP = POP_W'(MIN_STROKE);

   logic [WIDTH-1:0] prev_bits;
   logic [WIDTH-1:0] starts;

   // prev_bits[i] is the pixel left of column i; column 0 sees a virtual 0,
   // so a set bit 0 is counted as the start of a run.
   assign prev_bits = {row_data[WIDTH-2:0], 1'b0};
   assign starts    = row_data & ~prev_bits;

   always_comb begin
      // NOTE: outputs get a default before the loop so every path assigns
      // them; otherwise synthesis would infer latches.
      seg = '0;
      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         seg = seg + SEG_W'(starts[i]);
         pop = pop + POP_W'(row_data[i]);
      end
   end

   assign stroke = (seg == SEG_W'(1)) && (pop >= MIN_POP);

endmodule

// File: rtl/digit_feature_extractor.sv
// -----------------------------------------------------------------------------
// digit_feature_extractor
//
// Accepts a binary digit bitmap one row per cycle and reduces it to the
// (edges, curves) pair used by the perceptron classifier:
//   edges  - rows that are a single straight stroke, saturating at 7
//   curves - rows whose segment count differs from the previous row,
//            saturating at 15
// The finished pair is held under a valid/ready handshake.
//
// Ports:
//   clk         in   1        clock, rising edge
//   rst         in   1        asynchronous, active-high reset
//   row_data    in   WIDTH    pixel row, bit i = column i, 1 = ink
//   row_valid   in   1        row_data valid this cycle
//   row_ready   out  1        a row is accepted this cycle if row_valid
//   edges       out  EDGE_W   straight-stroke count (0 unless feat_valid)
//   curves      out  CURVE_W  segment-change count (0 unless feat_valid)
//   feat_valid  out  1        edges/curves hold a completed frame
//   feat_ready  in   1        consumer accepts the features
// -----------------------------------------------------------------------------
module digit_feature_extractor
   import digit_feature_extractor_pkg::*;
#(
   parameter int ROWS       = DEF_ROWS,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int MIN_STROKE = DEF_MIN_STROKE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   row_data,
   input  logic               row_valid,
   output logic               row_ready,
   output logic [EDGE_W-1:0]  edges,
   output logic [CURVE_W-1:0] curves,
   output logic               feat_valid,
   input  logic               feat_ready
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SEG_W = seg_width(WIDTH);
   localparam int POP_W = pop_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

   state_t             state;
   logic [CNT_W-1:0]   row_cnt;
   logic [SEG_W-1:0]   prev_seg;
   logic [EDGE_W-1:0]  edge_acc;
   logic [CURVE_W-1:0] curve_acc;

   logic [SEG_W-1:0]   seg;
   logic [POP_W-1:0]   pop;
   logic               stroke;

   logic               accept;
   logic               last_row;
   logic               handshake;
   logic [EDGE_W-1:0]  edge_nxt;
   logic [CURVE_W-1:0] curve_nxt;

   digit_feature_extractor_row_analyzer #(
      .WIDTH      (WIDTH),
      .MIN_STROKE (MIN_STROKE)
   ) u_row_analyzer (
      .row_data (row_data),
      .seg      (seg),
      .pop      (pop),
      .stroke   (stroke)
   );

   assign accept    = row_valid & row_ready;
   assign handshake = feat_valid & feat_ready;
   // Row 0 is always taken in IDLE, so only ACCUM can hold the last row.
   assign last_row  = (state == ACCUM) && (row_cnt == LAST_ROW);

   // Accumulator values after the current row; each saturates on its own.
   always_comb begin
      edge_nxt  = edge_acc;
      curve_nxt = curve_acc;
      if (stroke && (edge_acc != EDGE_MAX))
         edge_nxt = edge_acc + EDGE_W'(1);
      // row_cnt == 0 marks row 0, which has no predecessor to compare with.
      if ((row_cnt != '0) && (seg != prev_seg) && (curve_acc != CURVE_MAX))
         curve_nxt = curve_acc + CURVE_W'(1);
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         row_cnt    <= '0;
         prev_seg   <= '0;
         edge_acc   <= '0;
         curve_acc  <= '0;
         row_ready  <= 1'b1;
         feat_valid <= 1'b0;
         edges      <= '0;
         curves     <= '0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  edge_acc  <= edge_nxt;
                  curve_acc <= curve_nxt;
                  prev_seg  <= seg;
                  if (last_row) begin
                     // Counter holds at ROWS-1; it only clears on handshake.
                     state      <= DONE;
                     row_ready  <= 1'b0;
                     feat_valid <= 1'b1;
                     edges      <= edge_nxt;
                     curves     <= curve_nxt;
                  end else begin
                     state   <= ACCUM;
                     row_cnt <= row_cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (handshake) begin
                  // row_ready comes back one cycle after the handshake edge.
                  state      <= IDLE;
                  row_cnt    <= '0;
                  prev_seg   <= '0;
                  edge_acc   <= '0;
                  curve_acc  <= '0;
                  row_ready  <= 1'b1;
                  feat_valid <= 1'b0;
                  edges      <= '0;
                  curves     <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               row_cnt   <= '0;
               row_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/digit_feature_extractor.md
Name: digit_feature_extractor

Overview:
- Streams a binary digit bitmap one row per cycle and reduces it to the (edges, curves) feature pair that the downstream perceptron classifier consumes.
- Sits between the pixel source (input pins or bitmap buffer) and the classifier.
- Holds the finished feature pair under a valid/ready handshake until the classifier side accepts it.

Parameters:
- ROWS, 8, rows per frame (>=2).
- WIDTH, 8, pixels per row.
- MIN_STROKE, 4, minimum single-run popcount that counts as a straight stroke.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- row_data  input  WIDTH  pixel row; bit i = column i; 1 = ink.
- row_valid  input  1  row_data valid this cycle.
- row_ready  output  1  block accepts a row this cycle.
- edges  output  3  straight-stroke count, saturating at 7.
- curves  output  4  segment-count-change count, saturating at 15.
- feat_valid  output  1  edges/curves hold a completed frame.
- feat_ready  input  1  consumer accepts the features.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, row counter=0, prev_seg=0, accumulators=0.
  - Outputs: row_ready=1, feat_valid=0, edges=0, curves=0.
- Row accept: a row is taken on a cycle with row_valid & row_ready. Cycles with row_valid=0 are bubbles and change nothing.
- Per-row analysis (combinational on row_data):
  - seg = number of 0->1 transitions scanning bit 0 upward, with bit 0 set counting as a start; 0..WIDTH/2.
  - pop = popcount.
  - stroke = (seg==1) && (pop>=MIN_STROKE).
- Accumulation on each accepted row r:
  - If stroke, edge_acc += 1, saturating at 7.
  - If r>0 and seg != prev_seg, curve_acc += 1, saturating at 15.
  - prev_seg <= seg; row counter += 1.
- States:
  - IDLE: row_ready=1. An accepted row becomes row 0; go to ACCUM (or DONE if ROWS==1, not supported; ROWS>=2).
  - ACCUM: row_ready=1. The accepted row with counter==ROWS-1 is the last row; go to DONE.
  - DONE: row_ready=0, feat_valid=1, edges/curves = final accumulators.
    - Outputs stay stable while feat_ready=0.
    - On feat_valid & feat_ready: clear accumulators, counter and prev_seg; go to IDLE.
    - row_ready rises the following cycle; never in the same cycle as the output handshake.
- Latency: last row accepted in cycle N -> feat_valid=1 from cycle N+1. Minimum frame period is ROWS+1 cycles.
- Outputs are registered. edges/curves read 0 whenever feat_valid=0.
- Saturation is per accumulator and independent; counters never wrap.
- Reset mid-frame or in DONE: partial frame discarded, feat_valid drops immediately, next accepted row is row 0.
- Row counter width is clog2(ROWS); it returns to 0 only via output handshake or reset.

Decomposition:
- Shared package (classifier feature constants):
  - EDGE_W=3, CURVE_W=4, EDGE_MAX=7, CURVE_MAX=15.
  - State enum {IDLE, ACCUM, DONE}.
  - Default ROWS/WIDTH.
- One combinational sub-module, row_analyzer: row_data in; seg, pop, stroke out.
- The top holds the FSM, counter and accumulators.

Test Plan:
- Eight rows of 8'b00011000 -> seg=1, pop=2 each; edges=0, curves=0, feat_valid one cycle after row 7.
- Eight rows of 8'hFF -> 8 strokes; edges saturates to 7; curves=0.
- Rows alternating 8'hFF, 8'h81, starting with 8'hFF, x4 pairs -> seg 1,2,1,2,...; edges=4, curves=7.
- Rows alternating 8'h00, 8'hAA -> seg 0,4,...; edges=0, curves=7. Insert row_valid=0 bubbles between rows -> identical result.
- Backpressure:
  - After a frame completes, hold feat_ready=0 for 5 cycles -> feat_valid=1, outputs stable, row_ready=0, offered rows not consumed.
  - Assert feat_ready -> next cycle feat_valid=0, row_ready=1; the next frame computes correctly.
- Assert rst after 3 rows of 8'hFF -> outputs 0 immediately; a following 8x 8'h18 frame yields edges=0, curves=0.
